// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter feeding one byte-wide UART, with sync prefix and tx_done watchdog
module uart_tx_arbiter #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter bit         SYNC_EN        = 1'b1,
  parameter int         TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  input  logic       a_last,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  input  logic       b_last,
  output logic       b_ready,
  input  logic       tx_done,
  output logic [7:0] uart_din,
  output logic       uart_tx_start,
  output logic [1:0] grant,
  output logic       busy,
  output logic       tx_timeout,
  input  logic       err_clr
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, WAIT_SYNC, SEND, WAIT_DATA} state_t;
  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            ptr_b_q, ptr_b_d;
  logic            last_q, last_d;
  logic [7:0]      din_q, din_d;
  logic            start_q, start_d;
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_wait, expire, done, pick_b, sel_valid, sel_last;
  logic [7:0]      sel_data;
  always_comb begin
    in_wait   = (state_q == WAIT_SYNC) || (state_q == WAIT_DATA);
    expire    = in_wait && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    done      = in_wait && (tx_done || expire);
    pick_b    = b_valid && (!a_valid || !ptr_b_q);
    sel_valid = grant_q[1] ? b_valid : a_valid;
    sel_data  = grant_q[1] ? b_data : a_data;
    sel_last  = grant_q[1] ? b_last : a_last;
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_b_d   = ptr_b_q;
    last_d    = last_q;
    din_d     = din_q;
    start_d   = 1'b0;
    timeout_d = (timeout_q && !err_clr) || (expire && !tx_done);
    cnt_d     = in_wait ? cnt_q + CW'(1) : cnt_q;
    case (state_q)
      IDLE: if (a_valid || b_valid) begin
        grant_d = pick_b ? 2'b10 : 2'b01;
        if (SYNC_EN) begin
          state_d = WAIT_SYNC;
          start_d = 1'b1;
          din_d   = SYNC_BYTE;
          cnt_d   = '0;
        end else begin
          state_d = SEND;
        end
      end
      WAIT_SYNC: if (done) state_d = SEND;
      SEND: if (sel_valid) begin
        state_d = WAIT_DATA;
        start_d = 1'b1;
        din_d   = sel_data;
        last_d  = sel_last;
        cnt_d   = '0;
      end
      WAIT_DATA: if (done) begin
        state_d = last_q ? IDLE : SEND;
        grant_d = last_q ? 2'b00 : grant_q;
        ptr_b_d = last_q ? grant_q[1] : ptr_b_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      ptr_b_q   <= 1'b1;
      last_q    <= 1'b0;
      din_q     <= 8'h00;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_b_q   <= ptr_b_d;
      last_q    <= last_d;
      din_q     <= din_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end
  assign a_ready       = (state_q == SEND) && grant_q[0];
  assign b_ready       = (state_q == SEND) && grant_q[1];
  assign uart_din      = din_q;
  assign uart_tx_start = start_q;
  assign grant         = grant_q;
  assign busy          = state_q != IDLE;
  assign tx_timeout    = timeout_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single byte-wide UART transmitter between two packet sources. Source A is the visualizer sample stream; source B is status/debug messages. The block arbitrates round-robin at packet boundaries and prepends a sync byte to each packet. It sequences the UART with a one-cycle start pulse per byte, waits for the done pulse, and recovers from a missing done pulse with a watchdog.

Parameters:
SYNC_BYTE, 8'hA5, byte transmitted before every packet.
SYNC_EN, 1, 1 = prepend SYNC_BYTE; 0 = go straight to data.
TIMEOUT_CYCLES, 2000000, clk cycles to wait for tx_done before forcing completion (must be >= 2).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
a_valid  in  1  source A byte valid
a_data  in  8  source A byte
a_last  in  1  source A byte ends packet
a_ready  out  1  source A byte accepted this cycle
b_valid  in  1  source B byte valid
b_data  in  8  source B byte
b_last  in  1  source B byte ends packet
b_ready  out  1  source B byte accepted this cycle
tx_done  in  1  one-cycle pulse from UART: byte finished
uart_din  out  8  byte to UART, registered
uart_tx_start  out  1  one-cycle start pulse, registered
grant  out  2  one-hot owner, A=01, B=10, 00 when idle
busy  out  1  high whenever state != IDLE
tx_timeout  out  1  sticky: watchdog fired
err_clr  in  1  clears tx_timeout

Behaviour:
- Reset (async, reset_n=0): state IDLE, uart_din=8'h00, uart_tx_start=0, grant=00, busy=0, tx_timeout=0, round-robin pointer = "B last", so A wins the first tie. Reset mid-packet aborts the packet; partial bytes are not resent.
- States: IDLE, WAIT_SYNC, SEND, WAIT_DATA.
- IDLE: if only one valid is high, that source is granted. If both are high, the source not granted last wins.
  - SYNC_EN=1: next cycle uart_tx_start=1, uart_din=SYNC_BYTE, state becomes WAIT_SYNC.
  - SYNC_EN=0: state becomes SEND next cycle.
  - grant is registered together with the state change.
- WAIT_SYNC: on tx_done or watchdog expiry, state becomes SEND.
- SEND: x_ready = (state==SEND) && grant selects x. This is combinational from state/grant only; it does not depend on valid.
  - On granted valid&&ready: next cycle uart_tx_start=1, uart_din=data, last is latched, state becomes WAIT_DATA.
  - Granted valid low: hold SEND indefinitely (packet lock; the other source is blocked).
- WAIT_DATA: on tx_done or expiry, go to IDLE if the latched last=1, otherwise to SEND.
  - On the return to IDLE: the round-robin pointer is updated to the finishing source, and grant becomes 00.
- uart_tx_start is high for exactly one cycle per byte and never in two consecutive cycles.
- The ungranted source's ready is always 0.
- Latencies:
  - IDLE request at cycle 0 gives the sync start pulse at cycle 1.
  - tx_done at cycle t gives ready at t+1; with valid at t+1, the data start pulse is at t+2.
  - Last-byte tx_done at t gives IDLE at t+1; a new grant may occur at t+1, with its start pulse at t+2.
- Watchdog:
  - A counter is cleared on each start pulse and increments every cycle in WAIT_SYNC/WAIT_DATA.
  - When the counter reaches TIMEOUT_CYCLES-1 without tx_done, the byte is treated as done and tx_timeout is set.
  - tx_done in the same cycle as expiry counts as normal completion; no error is flagged.
- tx_done outside the WAIT states is ignored.
- err_clr clears tx_timeout. If a new expiry occurs in the same cycle as err_clr, the set wins.
- Upstream data is not registered beyond the handshake. Sources must hold data/last stable while valid is high and ready is low.

Test Plan:
- Single A packet 3 bytes (0x10, 0x20, 0x30 last), tx_done 5 cycles after each start -> uart_din sequence A5, 10, 20, 30. Exactly 4 start pulses. grant=01 throughout; returns to 00 and busy=0 after the final tx_done.
- a_valid and b_valid both asserted in IDLE after reset, each with a 2-byte packet -> A served first, then B. On the next tie B wins only if A finished last... sequence: A5, A0, A1, A5, B0, B1. No B byte interleaved into the A packet.
- A packet stalls (a_valid low for 50 cycles mid-packet) while b_valid stays high -> b_ready stays 0; the block holds SEND; A resumes and completes before B is granted.
- TIMEOUT_CYCLES=16, tx_done withheld after the sync byte -> state advances 16 cycles after the start pulse and tx_timeout=1. err_clr pulse gives tx_timeout=0. tx_done coincident with cycle 16 -> tx_timeout stays 0.
- SYNC_EN=0, B 1-byte packet 0x7E -> the only start pulse carries 7E. Spurious tx_done while IDLE -> no start and no state change.
- reset_n asserted between bytes 1 and 2 of an A packet -> all outputs at reset values immediately (async). After release with a_valid high, a fresh A5 sync start occurs 1 cycle after the first active clock edge.
